// File: rtl/game_pkg.sv
// Shared encodings for the Frogger play-loop sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam int         SPAWN_ROW = 0;
    localparam logic [2:0] MAX_LEVEL = 3'd7;

endpackage

// File: rtl/game_controller_rise_detect.sv
// One-bit rising-edge detector; after reset the input must be seen low once
// before a high level counts as a press.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic low_seen_r;

    // remembers whether the previous sampled level was low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_seen_r <= 1'b0;
        end else begin
            low_seen_r <= ~level;
        end
    end

    assign rise = level & low_seen_r;

endmodule

// File: rtl/game_controller.sv
// Frogger play-loop sequencer: frog position, lives/level, game FSM and the
// level-dependent vehicle-advance tick.
module game_controller
    import game_pkg::*;
#(
    parameter int DATAWIDTH_POS = 3,
    parameter int LIVES         = 3,
    parameter int START_X       = 3,
    parameter int BASE_PERIOD   = 50000000,
    parameter int PERIOD_STEP   = 5000000,
    parameter int MIN_PERIOD    = 10000000,
    parameter int HIT_CYCLES    = 25000000,
    parameter int WIN_CYCLES    = 25000000,
    parameter int CNT_WIDTH     = 26
) (
    input  logic                     GC_CLOCK_50,
    input  logic                     GC_RESET_InLow,
    input  logic                     GC_START_IN,
    input  logic                     GC_UP_IN,
    input  logic                     GC_DOWN_IN,
    input  logic                     GC_LEFT_IN,
    input  logic                     GC_RIGHT_IN,
    input  logic                     GC_PERDIO_IN,
    output logic [DATAWIDTH_POS-1:0] GC_POSX_OUT,
    output logic [DATAWIDTH_POS-1:0] GC_POSY_OUT,
    output logic [1:0]               GC_LIVES_OUT,
    output logic [2:0]               GC_LEVEL_OUT,
    output logic [2:0]               GC_STATE_OUT,
    output logic                     GC_TICK_OUT,
    output logic                     GC_GAMEOVER_OUT
);

    localparam int PW = CNT_WIDTH + 3;
    localparam logic [DATAWIDTH_POS-1:0] SPAWN_X    = DATAWIDTH_POS'(START_X);
    localparam logic [DATAWIDTH_POS-1:0] SPAWN_Y    = DATAWIDTH_POS'(SPAWN_ROW);
    localparam logic [DATAWIDTH_POS-1:0] POS_MAX    = {DATAWIDTH_POS{1'b1}};
    localparam logic [DATAWIDTH_POS-1:0] POS_ONE    = DATAWIDTH_POS'(1);
    localparam logic [1:0]               LIVES_INIT = 2'(LIVES);
    localparam logic [CNT_WIDTH-1:0]     HIT_LAST   = CNT_WIDTH'(HIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]     WIN_LAST   = CNT_WIDTH'(WIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]     CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [PW-1:0]            BASE_W     = PW'(BASE_PERIOD);
    localparam logic [PW-1:0]            STEP_W     = PW'(PERIOD_STEP);
    localparam logic [PW-1:0]            MIN_W      = PW'(MIN_PERIOD);

    logic start_rise_s, up_rise_s, down_rise_s, left_rise_s, right_rise_s;

    rise_detect u_rise_start (.clk(GC_CLOCK_50), .rst_n(GC_RESET_InLow), .level(GC_START_IN), .rise(start_rise_s));
    rise_detect u_rise_up    (.clk(GC_CLOCK_50), .rst_n(GC_RESET_InLow), .level(GC_UP_IN),    .rise(up_rise_s));
    rise_detect u_rise_down  (.clk(GC_CLOCK_50), .rst_n(GC_RESET_InLow), .level(GC_DOWN_IN),  .rise(down_rise_s));
    rise_detect u_rise_left  (.clk(GC_CLOCK_50), .rst_n(GC_RESET_InLow), .level(GC_LEFT_IN),  .rise(left_rise_s));
    rise_detect u_rise_right (.clk(GC_CLOCK_50), .rst_n(GC_RESET_InLow), .level(GC_RIGHT_IN), .rise(right_rise_s));

    state_t                   state_r, state_s;
    logic [DATAWIDTH_POS-1:0] posx_r, posx_s, posy_r, posy_s;
    logic [1:0]               lives_r, lives_s;
    logic [2:0]               level_r, level_s;
    logic [CNT_WIDTH-1:0]     frz_cnt_r, frz_cnt_s, tick_cnt_r, tick_cnt_s;
    logic                     tick_r, tick_s, gameover_r;
    logic [PW-1:0]            reduce_s, period_s;

    // tick period for the current level, floored without underflow
    always_comb begin
        reduce_s = PW'(level_r) * STEP_W;
        if ((BASE_W > reduce_s) && ((BASE_W - reduce_s) > MIN_W)) begin
            period_s = BASE_W - reduce_s;
        end else begin
            period_s = MIN_W;
        end
    end

    // game FSM next state, position, lives, level and freeze counter
    always_comb begin
        state_s   = state_r;
        posx_s    = posx_r;
        posy_s    = posy_r;
        lives_s   = lives_r;
        level_s   = level_r;
        frz_cnt_s = CNT_ZERO;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start_rise_s) begin
                    state_s = (state_r == ST_IDLE) ? ST_PLAY : ST_IDLE;
                    posx_s  = SPAWN_X;
                    posy_s  = SPAWN_Y;
                    lives_s = LIVES_INIT;
                    level_s = 3'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PLAY: begin
                // a collision wins over any move edge in the same cycle
                if (GC_PERDIO_IN) begin
                    state_s = ST_HIT;
                    lives_s = (lives_r != 2'd0) ? (lives_r - 2'd1) : 2'd0;
                end else if (up_rise_s) begin
                    if (posy_r == POS_MAX) begin
                        state_s = ST_WIN;
                    end else begin
                        posy_s = posy_r + POS_ONE;
                    end
                end else if (down_rise_s) begin
                    posy_s = (posy_r != SPAWN_Y) ? (posy_r - POS_ONE) : posy_r;
                end else if (left_rise_s) begin
                    posx_s = (posx_r != {DATAWIDTH_POS{1'b0}}) ? (posx_r - POS_ONE) : posx_r;
                end else if (right_rise_s) begin
                    posx_s = (posx_r != POS_MAX) ? (posx_r + POS_ONE) : posx_r;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (frz_cnt_r == HIT_LAST) begin
                    if (lives_r == 2'd0) begin
                        state_s = ST_OVER;
                    end else begin
                        state_s = ST_PLAY;
                        posx_s  = SPAWN_X;
                        posy_s  = SPAWN_Y;
                    end
                end else begin
                    frz_cnt_s = frz_cnt_r + CNT_ONE;
                end
            end
            ST_WIN: begin
                if (frz_cnt_r == WIN_LAST) begin
                    state_s = ST_PLAY;
                    posx_s  = SPAWN_X;
                    posy_s  = SPAWN_Y;
                    level_s = (level_r != MAX_LEVEL) ? (level_r + 3'd1) : level_r;
                end else begin
                    frz_cnt_s = frz_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                posx_s  = SPAWN_X;
                posy_s  = SPAWN_Y;
                lives_s = LIVES_INIT;
                level_s = 3'd0;
            end
        endcase
    end

    // vehicle tick: runs only while staying in PLAY, cleared on any exit
    always_comb begin
        if ((state_r == ST_PLAY) && (state_s == ST_PLAY)) begin
            if (PW'(tick_cnt_r) == (period_s - PW'(1))) begin
                tick_s     = 1'b1;
                tick_cnt_s = CNT_ZERO;
            end else begin
                tick_s     = 1'b0;
                tick_cnt_s = tick_cnt_r + CNT_ONE;
            end
        end else begin
            tick_s     = 1'b0;
            tick_cnt_s = CNT_ZERO;
        end
    end

    // state and output registers
    always_ff @(posedge GC_CLOCK_50 or negedge GC_RESET_InLow) begin
        if (!GC_RESET_InLow) begin
            state_r    <= ST_IDLE;
            posx_r     <= SPAWN_X;
            posy_r     <= SPAWN_Y;
            lives_r    <= LIVES_INIT;
            level_r    <= 3'd0;
            frz_cnt_r  <= CNT_ZERO;
            tick_cnt_r <= CNT_ZERO;
            tick_r     <= 1'b0;
            gameover_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            posx_r     <= posx_s;
            posy_r     <= posy_s;
            lives_r    <= lives_s;
            level_r    <= level_s;
            frz_cnt_r  <= frz_cnt_s;
            tick_cnt_r <= tick_cnt_s;
            tick_r     <= tick_s;
            gameover_r <= (state_s == ST_OVER);
        end
    end

    assign GC_POSX_OUT     = posx_r;
    assign GC_POSY_OUT     = posy_r;
    assign GC_LIVES_OUT    = lives_r;
    assign GC_LEVEL_OUT    = level_r;
    assign GC_STATE_OUT    = state_r;
    assign GC_TICK_OUT     = tick_r;
    assign GC_GAMEOVER_OUT = gameover_r;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with small timing parameters.
module tb_game_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, perdio = 1'b0;
    logic [2:0] posx, posy, level, state;
    logic [1:0] lives;
    logic tick, gameover;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_controller #(
        .DATAWIDTH_POS(3), .LIVES(3), .START_X(3), .BASE_PERIOD(8), .PERIOD_STEP(2),
        .MIN_PERIOD(4), .HIT_CYCLES(4), .WIN_CYCLES(3), .CNT_WIDTH(26)
    ) dut (
        .GC_CLOCK_50(clk), .GC_RESET_InLow(rst_n), .GC_START_IN(start),
        .GC_UP_IN(up), .GC_DOWN_IN(down), .GC_LEFT_IN(left), .GC_RIGHT_IN(right),
        .GC_PERDIO_IN(perdio), .GC_POSX_OUT(posx), .GC_POSY_OUT(posy),
        .GC_LIVES_OUT(lives), .GC_LEVEL_OUT(level), .GC_STATE_OUT(state),
        .GC_TICK_OUT(tick), .GC_GAMEOVER_OUT(gameover)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: down = v;
            2: left = v;
            3: right = v;
            default: start = v;
        endcase
    endtask

    // 0=UP 1=DOWN 2=LEFT 3=RIGHT 4=START; two cycles, result visible on return
    task automatic press(input int b);
        set_btn(b, 1'b1);
        @(negedge clk);
        set_btn(b, 1'b0);
        @(negedge clk);
    endtask

    task automatic wait_tick(input int exp_gap, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick && k < 40);
        chk(tag, k, exp_gap);
    endtask

    task automatic collide(input int exp_lives);
        press(0);
        perdio = 1'b1;
        @(negedge clk);
        perdio = 1'b0;
        chk("col_state", state, 2);
        chk("col_lives", lives, exp_lives);
        repeat (4) @(negedge clk);
    endtask

    task automatic win_level(input int exp_level);
        repeat (7) press(0);
        chk("climb_y7", posy, 7);
        up = 1'b1;
        @(negedge clk);
        up = 1'b0;
        chk("win_state", state, 3);
        chk("win_pos_y", posy, 7);
        @(negedge clk);
        chk("win_hold1", state, 3);
        @(negedge clk);
        chk("win_hold2", state, 3);
        @(negedge clk);
        chk("win_exit_state", state, 1);
        chk("win_level", level, exp_level);
        chk("win_pos_x", posx, 3);
        chk("win_pos_y0", posy, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_posx", posx, 3);
        chk("rst_posy", posy, 0);
        chk("rst_lives", lives, 3);
        chk("rst_level", level, 0);
        chk("rst_tick", tick, 0);
        chk("rst_gameover", gameover, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // start, then tick every 8 clocks at level 0
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_state", state, 1);
        chk("start_posx", posx, 3);
        chk("start_lives", lives, 3);
        chk("start_tick0", tick, 0);
        wait_tick(8, "tick_gap_l0_first");
        wait_tick(8, "tick_gap_l0_second");

        // left moves saturate at column 0
        press(2); chk("left1", posx, 2);
        press(2); chk("left2", posx, 1);
        press(2); chk("left3", posx, 0);
        press(2); chk("left4_sat", posx, 0);
        up = 1'b1; right = 1'b1;
        @(negedge clk);
        up = 1'b0; right = 1'b0;
        @(negedge clk);
        chk("prio_x", posx, 0);
        chk("prio_y", posy, 1);
        press(1); chk("down_y", posy, 0);
        press(1); chk("down_sat", posy, 0);
        press(0); press(0);
        repeat (3) press(3);
        chk("pos_x3", posx, 3);
        chk("pos_y2", posy, 2);

        // collision beats a simultaneous UP edge; detector ignored while frozen
        perdio = 1'b1; up = 1'b1;
        @(negedge clk);
        up = 1'b0;
        chk("hit_state", state, 2);
        chk("hit_lives", lives, 2);
        chk("hit_posy", posy, 2);
        @(negedge clk);
        chk("hit_tick_a", tick, 0);
        perdio = 1'b0;
        @(negedge clk);
        chk("hit_hold", state, 2);
        @(negedge clk);
        chk("hit_tick_b", tick, 0);
        @(negedge clk);
        chk("hit_exit_state", state, 1);
        chk("hit_exit_posy", posy, 0);
        chk("hit_exit_lives", lives, 2);

        // lose the remaining lives, then restart
        collide(1);
        chk("respawn_state", state, 1);
        collide(0);
        chk("over_state", state, 4);
        chk("over_flag", gameover, 1);
        press(4);
        chk("restart_state", state, 0);
        chk("restart_lives", lives, 3);
        chk("restart_flag", gameover, 0);
        press(4);
        chk("replay_state", state, 1);

        // level-ups shorten the tick period down to its floor
        win_level(1);
        wait_tick(6, "tick_gap_l1_first");
        wait_tick(6, "tick_gap_l1_second");
        win_level(2);
        wait_tick(4, "tick_gap_l2_first");
        wait_tick(4, "tick_gap_l2_second");

        // buttons held through reset must not act on release
        up = 1'b1; start = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_state", state, 0);
        chk("rst2_level", level, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_start_state", state, 0);
        up = 1'b0; start = 1'b0;
        @(negedge clk);
        press(4);
        chk("held_up_posy", posy, 0);
        chk("held_play_state", state, 1);

        // async reset in the middle of HIT
        collide(2);
        win_level(1);
        perdio = 1'b1;
        @(negedge clk);
        perdio = 1'b0;
        chk("midhit_state", state, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_lives", lives, 3);
        chk("arst_level", level, 0);
        chk("arst_posx", posx, 3);
        chk("arst_posy", posy, 0);
        chk("arst_tick", tick, 0);
        chk("arst_gameover", gameover, 0);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
